regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback stage that merges ALU and load-unit results and drives the single write port (we, rd_addr, rd_din) of the RV32 register file. Load results are sign/zero-extended, buffered in a small FIFO and interleaved with ALU results under an ALU-priority policy with starvation protection. An optional bypass path lets the decode stage see the write currently being presented to the register file.

## Interface
- LSU_DEPTH, 2: load-result FIFO entries; power of two, at least 2.
- STARVE_MAX, 4: consecutive cycles a non-empty FIFO may lose to the ALU before the ALU is stalled; range 1..15.

Reset is synchronous, active-low (rstn sampled on the rising edge of clk).

- clk in 1: clock; all state updates on the rising edge.
- rstn in 1: synchronous active-low reset.
- alu_valid in 1: ALU result present.
- alu_ready out 1: ALU result accepted this cycle when high with alu_valid.
- alu_rd in 5: ALU destination register.
- alu_data in 32: ALU result.
- lsu_valid in 1: load result present.
- lsu_ready out 1: FIFO can accept.
- lsu_rd in 5: load destination register.
- lsu_funct3 in 3: load type.
- lsu_addr_lo in 2: byte offset of the load address.
- lsu_data in 32: raw aligned memory word.
- we out 1: register file write enable.
- rd_addr out 5: register file write address.
- rd_din out 32: register file write data.
- rs1_addr in 5: decode read address 1, used for bypass.
- rs2_addr in 5: decode read address 2, used for bypass.
- rs1_fwd_valid out 1 / rs1_fwd_data out 32: bypass hit and data for rs1.
- rs2_fwd_valid out 1 / rs2_fwd_data out 32: bypass hit and data for rs2.
- lsu_pending out 1: FIFO non-empty.

## Operation
- **Handshakes:** a transfer occurs on a rising edge where valid && ready.
  - lsu_ready = (FIFO count < LSU_DEPTH), from registered count only; no pop-through.
  - alu_ready = (starve_cnt != STARVE_MAX).
- **Load extension** is applied at enqueue; the FIFO stores the 32-bit final value.
  - 000 LB: byte lsu_addr_lo, sign-extend.
  - 001 LH: half lsu_addr_lo[1], sign-extend.
  - 010 LW: full word.
  - 100 LBU, 101 LHU: as LB/LH, zero-extend.
  - Other codes are treated as LW.
- **x0:** a transfer with rd == 0 (either source) completes its handshake but is discarded. It is never enqueued, never raises we, and does not count as an ALU win.
- **Select, per cycle:**
  - Accepted ALU result with rd != 0: write ALU.
  - Otherwise, FIFO non-empty: pop head and write it.
  - Otherwise: we = 0.
- **starve_cnt (4 bits):**
  - Clears on reset, on a FIFO pop, or when the FIFO is empty.
  - Increments when the FIFO is non-empty and the ALU wins.
  - At STARVE_MAX, alu_ready drops, forcing a FIFO pop that cycle, after which the counter clears.
- **Ordering:** cross-source ordering to the same rd is the issuer's responsibility. Within the FIFO, order is strictly preserved.
- **Bypass:** rsN_fwd_valid = we && rd_addr == rsN_addr && rsN_addr != 0; rsN_fwd_data = rd_din. Both are combinational from the output registers.

## Timing
- ALU latency: accepted in cycle N, we/rd_addr/rd_din registered and visible in cycle N+1.
- LSU latency: accepted in cycle N, earliest write visible in cycle N+2.
- we is high for exactly one cycle per write; rd_addr/rd_din hold their last value while we = 0.
- Reset values:
  - Outputs: we = 0, rd_addr = 0, rd_din = 0, fwd_valid = 0, fwd_data = 0, lsu_pending = 0.
  - State: FIFO empty, starve_cnt = 0.
  - Handshakes: alu_ready = 1, lsu_ready = 1 from the first cycle after reset.
- Reset mid-operation: FIFO contents are discarded and no write is emitted in the cycle following the reset edge.
- FIFO full: lsu_ready = 0. A simultaneous pop does not raise ready until the next cycle.
- FIFO pointers wrap modulo LSU_DEPTH; count width is log2(LSU_DEPTH)+1.

## Configuration
- **REGFILE_WB_BYPASS_EN defined:** bypass logic is built as described in Operation.
- **Not defined:** the rs1/rs2 fwd ports still exist, but fwd_valid and fwd_data are tied to 0 and rs1_addr/rs2_addr are unused. All other behaviour is identical.

## Structure
- **Shared package:**
  - load funct3 constants (LB, LH, LW, LBU, LHU);
  - REG_ADDR_W = 5, XLEN = 32;
  - a typedef for the writeback entry {rd[4:0], data[31:0]}.
- **Sub-module:** one, wb_fifo. It is a parameterised synchronous FIFO of writeback entries with count, full and empty outputs, and it is reset by rstn.
- Load extension, arbitration, starvation counter and bypass live in the top module.

## Test plan
- **Reset:** hold rstn = 0 for 3 cycles with alu_valid = 1 → we = 0, rd_din = 0, lsu_ready = 1 after release.
- **ALU write:** alu_rd = 5, alu_data = 0xDEADBEEF in cycle N → we = 1, rd_addr = 5, rd_din = 0xDEADBEEF in N+1. With bypass, rs1_addr = 5 gives rs1_fwd_valid = 1.
- **Load extension:**
  - LB, lsu_addr_lo = 3, lsu_data = 0x80123456 → rd_din = 0xFFFFFF80.
  - LHU, lsu_addr_lo = 2, same data → rd_din = 0x00008012.
  - Both writes appear 2 cycles after accept.
- **Priority and starvation:** enqueue one load to rd = 7, then hold alu_valid = 1 to rd = 3 with STARVE_MAX = 4 → 4 ALU writes, then alu_ready = 0 for one cycle and rd = 7 written, then ALU resumes.
- **FIFO full:** with LSU_DEPTH = 2, push 3 loads while the ALU is continuously valid → lsu_ready = 0 after 2 accepts. The third load is accepted only after a pop, and the written rd order matches push order.
- **x0 discard:** ALU write to rd = 0 plus a pending load to rd = 9 in the same cycle → no x0 write, and rd = 9 is written that cycle.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// -----------------------------------------------------------------------------
// regfile_writeback_pkg
// Shared definitions for the RV32 register-file writeback stage:
//   - register address and data widths
//   - load funct3 encodings
//   - the writeback entry type {rd, data} held in the load-result FIFO
//   - load_extend(): byte/half/word selection and sign/zero extension
// -----------------------------------------------------------------------------
package regfile_writeback_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   // Extracts the addressed byte/half from an aligned word and extends it.
   // Unknown funct3 codes fall back to a full-word load.
   function automatic logic [XLEN-1:0] load_extend(
      input logic [2:0]      funct3,
      input logic [1:0]      addr_lo,
      input logic [XLEN-1:0] word
   );
      logic [7:0]      byte_v;
      logic [15:0]     half_v;
      logic [XLEN-1:0] res_v;
      byte_v = word[{addr_lo, 3'b000} +: 8];
      half_v = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   res_v = {{24{byte_v[7]}}, byte_v};
         F3_LH:   res_v = {{16{half_v[15]}}, half_v};
         F3_LBU:  res_v = {24'h000000, byte_v};
         F3_LHU:  res_v = {16'h0000, half_v};
         F3_LW:   res_v = word;
         default: res_v = word;
      endcase
      return res_v;
   endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of writeback entries used to buffer extended load results.
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// Ports:
//   clk, rstn         clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   enqueue request and entry (ignored when full)
//   pop, pop_data     dequeue request (ignored when empty) and head entry
//   count             occupancy, $clog2(DEPTH)+1 bits
//   full, empty       occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module wb_fifo
   import regfile_writeback_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  wb_entry_t                push_data,
   input  logic                     pop,
   output wb_entry_t                pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t              mem_q [DEPTH];
   wb_entry_t              mem_d [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   push_ok_s;
   logic                   pop_ok_s;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == {CNT_W{1'b0}});
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Next-state for pointers, occupancy and storage.
   always_comb begin
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards all contents.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// RV32 writeback stage: merges ALU results and extended load results onto the
// single register-file write port. ALU results have priority; a starvation
// counter stalls the ALU after STARVE_MAX consecutive losses by a non-empty
// load FIFO. Writes to x0 complete their handshake and are dropped.
//
// Build option: define REGFILE_WB_BYPASS_EN to build the decode bypass
// (rsN_fwd_valid/rsN_fwd_data). Without it those outputs are tied to 0.
//
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data              ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_funct3/
//   lsu_addr_lo/lsu_data                             load result handshake
//   we, rd_addr, rd_din             registered register-file write port
//   rs1_addr, rs2_addr              decode read addresses (bypass lookup)
//   rs1_fwd_valid/data, rs2_fwd_valid/data           bypass hit and value
//   lsu_pending                     load FIFO non-empty
// -----------------------------------------------------------------------------
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int LSU_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [2:0]  lsu_funct3,
   input  logic [1:0]  lsu_addr_lo,
   input  logic [31:0] lsu_data,
   output logic        we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_din,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic        rs1_fwd_valid,
   output logic [31:0] rs1_fwd_data,
   output logic        rs2_fwd_valid,
   output logic [31:0] rs2_fwd_data,
   output logic        lsu_pending
);

   localparam int CNT_W = $clog2(LSU_DEPTH) + 1;

   logic                  we_q, we_d;
   logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]       rd_din_q, rd_din_d;
   logic [3:0]            starve_q, starve_d;

   logic                  alu_ready_s;
   logic                  lsu_ready_s;
   logic                  alu_fire_s;
   logic                  alu_win_s;
   logic                  lsu_fire_s;
   logic                  push_s;
   logic                  pop_s;
   wb_entry_t             push_entry_s;
   wb_entry_t             head_entry_s;
   logic [CNT_W-1:0]      fifo_count_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic                  unused_s;

   // Readiness depends only on registered state, never on same-cycle pops.
   assign alu_ready_s = (starve_q != 4'(STARVE_MAX));
   assign lsu_ready_s = (fifo_count_s < CNT_W'(LSU_DEPTH));
   assign alu_ready   = alu_ready_s;
   assign lsu_ready   = lsu_ready_s;
   assign lsu_pending = !fifo_empty_s;

   assign we      = we_q;
   assign rd_addr = rd_addr_q;
   assign rd_din  = rd_din_q;

   // Handshake decode, x0 filtering and the ALU-first arbitration decision.
   always_comb begin
      alu_fire_s = alu_valid && alu_ready_s;
      alu_win_s  = alu_fire_s && (alu_rd != 5'd0);
      lsu_fire_s = lsu_valid && lsu_ready_s;
      push_s     = lsu_fire_s && (lsu_rd != 5'd0);
      // An x0 ALU transfer does not occupy the port, so the FIFO may use it.
      pop_s      = !alu_win_s && !fifo_empty_s;
   end

   // Load extension happens before enqueue so the FIFO holds final values.
   always_comb begin
      push_entry_s.rd   = lsu_rd;
      push_entry_s.data = load_extend(lsu_funct3, lsu_addr_lo, lsu_data);
   end

   wb_fifo #(
      .DEPTH (LSU_DEPTH)
   ) u_wb_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .pop_data  (head_entry_s),
      .count     (fifo_count_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Write-port next state; address and data hold while no write occurs.
   always_comb begin
      we_d      = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_din_d  = rd_din_q;
      if (alu_win_s) begin
         we_d      = 1'b1;
         rd_addr_d = alu_rd;
         rd_din_d  = alu_data;
      end else if (pop_s) begin
         we_d      = 1'b1;
         rd_addr_d = head_entry_s.rd;
         rd_din_d  = head_entry_s.data;
      end else begin
         we_d      = 1'b0;
      end
   end

   // Starvation counter: counts ALU wins over a waiting FIFO entry.
   always_comb begin
      if (fifo_empty_s || pop_s) begin
         starve_d = 4'd0;
      end else if (alu_win_s) begin
         starve_d = starve_q + 4'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // Output and starvation registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         we_q      <= 1'b0;
         rd_addr_q <= 5'd0;
         rd_din_q  <= 32'h0000_0000;
         starve_q  <= 4'd0;
      end else begin
         we_q      <= we_d;
         rd_addr_q <= rd_addr_d;
         rd_din_q  <= rd_din_d;
         starve_q  <= starve_d;
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   // Bypass compares decode addresses against the write being presented.
   always_comb begin
      rs1_fwd_valid = we_q && (rd_addr_q == rs1_addr) && (rs1_addr != 5'd0);
      rs2_fwd_valid = we_q && (rd_addr_q == rs2_addr) && (rs2_addr != 5'd0);
      rs1_fwd_data  = rd_din_q;
      rs2_fwd_data  = rd_din_q;
   end

   assign unused_s = fifo_full_s;
`else
   // Bypass not built: forwarding outputs are constant zero.
   always_comb begin
      rs1_fwd_valid = 1'b0;
      rs2_fwd_valid = 1'b0;
      rs1_fwd_data  = 32'h0000_0000;
      rs2_fwd_data  = 32'h0000_0000;
   end

   assign unused_s = fifo_full_s ^ (^rs1_addr) ^ (^rs2_addr);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
// Directed self-checking bench for regfile_writeback (LSU_DEPTH=2,
// STARVE_MAX=4). Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, i.e. after the registers have settled.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rstn;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_addr_lo;
   logic [31:0] lsu_data;
   logic        we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_din;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        rs1_fwd_valid;
   logic [31:0] rs1_fwd_data;
   logic        rs2_fwd_valid;
   logic [31:0] rs2_fwd_data;
   logic        lsu_pending;

   int n_cmp = 0;
   int n_err = 0;
   logic [4:0] wr_rd_q[$];

   always #5 clk = ~clk;

   regfile_writeback #(
      .LSU_DEPTH  (2),
      .STARVE_MAX (4)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .lsu_valid     (lsu_valid),
      .lsu_ready     (lsu_ready),
      .lsu_rd        (lsu_rd),
      .lsu_funct3    (lsu_funct3),
      .lsu_addr_lo   (lsu_addr_lo),
      .lsu_data      (lsu_data),
      .we            (we),
      .rd_addr       (rd_addr),
      .rd_din        (rd_din),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_fwd_valid (rs1_fwd_valid),
      .rs1_fwd_data  (rs1_fwd_data),
      .rs2_fwd_valid (rs2_fwd_valid),
      .rs2_fwd_data  (rs2_fwd_data),
      .lsu_pending   (lsu_pending)
   );

   // Record the destination of every register-file write.
   always @(negedge clk) begin
      if (rstn === 1'b1 && we === 1'b1) wr_rd_q.push_back(rd_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int count_not(input logic [4:0] skip_rd);
      int n = 0;
      foreach (wr_rd_q[i]) if (wr_rd_q[i] != skip_rd) n++;
      return n;
   endfunction

   task automatic test_reset();
      rstn = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
      repeat (3) tick();
      n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", we); end
      n_cmp++; if (rd_din !== 32'h0) begin n_err++; $display("FAIL reset_rd_din: got %h want 0", rd_din); end
      n_cmp++; if (rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
      n_cmp++; if (lsu_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", lsu_pending); end
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end
      n_cmp++; if (rs1_fwd_valid !== 1'b0 || rs1_fwd_data !== 32'h0) begin n_err++; $display("FAIL reset_fwd: got %b/%h want 0/0", rs1_fwd_valid, rs1_fwd_data); end
      rstn = 1'b1; alu_valid = 1'b0;
      tick();
      n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL reset_lsu_ready: got %b want 1", lsu_ready); end
      n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_release_we: got %b want 0", we); end
   endtask

   task automatic test_alu_write();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      tick();
      alu_valid = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
      #1;
      n_cmp++; if (we !== 1'b1 || rd_addr !== 5'd5 || rd_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_write: got we=%b rd=%0d din=%h want 1/5/deadbeef", we, rd_addr, rd_din); end
`ifdef REGFILE_WB_BYPASS_EN
      n_cmp++; if (rs1_fwd_valid !== 1'b1 || rs1_fwd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_fwd_rs1: got %b/%h want 1/deadbeef", rs1_fwd_valid, rs1_fwd_data); end
`else
      n_cmp++; if (rs1_fwd_valid !== 1'b0 || rs1_fwd_data !== 32'h0) begin n_err++; $display("FAIL alu_fwd_rs1: got %b/%h want 0/0", rs1_fwd_valid, rs1_fwd_data); end
`endif
      n_cmp++; if (rs2_fwd_valid !== 1'b0) begin n_err++; $display("FAIL alu_fwd_rs2: got %b want 0", rs2_fwd_valid); end
      tick();
      n_cmp++; if (we !== 1'b0 || rd_addr !== 5'd5 || rd_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_hold: got we=%b rd=%0d din=%h want 0/5/deadbeef", we, rd_addr, rd_din); end
      n_cmp++; if (rs1_fwd_valid !== 1'b0) begin n_err++; $display("FAIL alu_fwd_idle: got %b want 0", rs1_fwd_valid); end
      rs1_addr = 5'd0; rs2_addr = 5'd0;
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3  [10] = '{3'b000, 3'b101, 3'b001, 3'b001, 3'b100, 3'b000, 3'b010, 3'b011, 3'b000, 3'b100};
      logic [1:0]  lo  [10] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
      logic [31:0] exp [10] = '{32'hFFFF_FF80, 32'h0000_8012, 32'hFFFF_8012, 32'h0000_3456, 32'h0000_0080,
                                32'h0000_0056, 32'h8012_3456, 32'h8012_3456, 32'h0000_0034, 32'h0000_0012};
      for (int i = 0; i < 10; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_funct3 = f3[i]; lsu_addr_lo = lo[i]; lsu_data = 32'h8012_3456;
         tick();
         lsu_valid = 1'b0;
         n_cmp++; if (we !== 1'b0 || lsu_pending !== 1'b1) begin n_err++; $display("FAIL load_n1[%0d]: got we=%b pend=%b want 0/1", i, we, lsu_pending); end
         tick();
         n_cmp++; if (we !== 1'b1 || rd_addr !== 5'(10 + i) || rd_din !== exp[i]) begin n_err++; $display("FAIL load_n2[%0d]: got we=%b rd=%0d din=%h want 1/%0d/%h", i, we, rd_addr, rd_din, 10 + i, exp[i]); end
      end
      tick();
   endtask

   task automatic test_starvation();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0; lsu_data = 32'h7777_0007;
      tick();
      lsu_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3;
      for (int i = 0; i < 4; i++) begin
         alu_data = 32'h3333_0000 + 32'(i);
         n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_ready[%0d]: got %b want 1", i, alu_ready); end
         tick();
         n_cmp++; if (we !== 1'b1 || rd_addr !== 5'd3 || rd_din !== 32'h3333_0000 + 32'(i)) begin n_err++; $display("FAIL starve_alu[%0d]: got we=%b rd=%0d din=%h want 1/3", i, we, rd_addr, rd_din); end
      end
      n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL starve_stall: got alu_ready=%b want 0", alu_ready); end
      alu_data = 32'h3333_00FF;
      tick();
      n_cmp++; if (we !== 1'b1 || rd_addr !== 5'd7 || rd_din !== 32'h7777_0007) begin n_err++; $display("FAIL starve_pop: got we=%b rd=%0d din=%h want 1/7/77770007", we, rd_addr, rd_din); end
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL starve_resume_ready: got %b want 1", alu_ready); end
      tick();
      n_cmp++; if (we !== 1'b1 || rd_addr !== 5'd3 || rd_din !== 32'h3333_00FF) begin n_err++; $display("FAIL starve_resume: got we=%b rd=%0d din=%h want 1/3/333300ff", we, rd_addr, rd_din); end
      alu_valid = 1'b0;
      tick();
      n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL starve_idle: got we=%b want 0", we); end
   endtask

   task automatic test_fifo_full();
      logic saw_pop = 1'b0;
      int   k;
      wr_rd_q.delete();
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0044;
      lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0;
      for (int i = 0; i < 2; i++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(12 + i); lsu_data = 32'(12 + i);
         n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL full_accept[%0d]: got lsu_ready=%b want 1", i, lsu_ready); end
         tick();
      end
      lsu_rd = 5'd14; lsu_data = 32'd14;
      n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low: got %b want 0", lsu_ready); end
      k = 0;
      while (lsu_ready !== 1'b1 && k < 20) begin
         if (alu_ready === 1'b0) saw_pop = 1'b1;
         tick();
         k++;
      end
      n_cmp++; if (lsu_ready !== 1'b1 || saw_pop !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop: got ready=%b pop_seen=%b want 1/1", lsu_ready, saw_pop); end
      tick();
      lsu_valid = 1'b0;
      k = 0;
      while (count_not(5'd4) < 3 && k < 40) begin
         tick();
         k++;
      end
      alu_valid = 1'b0;
      tick();
      tick();
      n_cmp++; if (count_not(5'd4) != 3) begin n_err++; $display("FAIL full_load_count: got %0d want 3", count_not(5'd4)); end
      k = 0;
      foreach (wr_rd_q[i]) begin
         if (wr_rd_q[i] != 5'd4) begin
            n_cmp++; if (wr_rd_q[i] !== 5'(12 + k)) begin n_err++; $display("FAIL full_order[%0d]: got rd=%0d want %0d", k, wr_rd_q[i], 12 + k); end
            k++;
         end
      end
   endtask

   task automatic test_x0();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0; lsu_data = 32'h0000_0099;
      tick();
      lsu_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_0BAD;
      n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_alu_ready: got %b want 1", alu_ready); end
      tick();
      alu_valid = 1'b0;
      n_cmp++; if (we !== 1'b1 || rd_addr !== 5'd9 || rd_din !== 32'h0000_0099) begin n_err++; $display("FAIL x0_alu_discard: got we=%b rd=%0d din=%h want 1/9/00000099", we, rd_addr, rd_din); end
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_0F00;
      tick();
      lsu_valid = 1'b0;
      n_cmp++; if (lsu_pending !== 1'b0) begin n_err++; $display("FAIL x0_load_enq: got pending=%b want 0", lsu_pending); end
      tick();
      n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL x0_load_we: got we=%b want 0", we); end
   endtask

   task automatic test_reset_mid();
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0; lsu_data = 32'h0000_0020;
      tick();
      lsu_valid = 1'b0;
      n_cmp++; if (lsu_pending !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", lsu_pending); end
      rstn = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5555_5555;
      tick();
      n_cmp++; if (we !== 1'b0 || lsu_pending !== 1'b0 || rd_addr !== 5'd0 || rd_din !== 32'h0) begin n_err++; $display("FAIL mid_reset: got we=%b pend=%b rd=%0d din=%h want 0/0/0/0", we, lsu_pending, rd_addr, rd_din); end
      rstn = 1'b1; alu_valid = 1'b0;
      tick();
      n_cmp++; if (we !== 1'b0 || lsu_ready !== 1'b1) begin n_err++; $display("FAIL mid_after: got we=%b lsu_ready=%b want 0/1", we, lsu_ready); end
   endtask

   initial begin
      rstn = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_funct3 = 3'b000; lsu_addr_lo = 2'd0; lsu_data = 32'h0;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      test_reset();
      test_alu_write();
      test_load_ext();
      test_starvation();
      test_fifo_full();
      test_x0();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
